burst_ctr_arbiter: RTL and testbench
====================================

Name: burst_ctr_arbiter

Overview:
- Sequences and shares one loadable up-counter (WE/IE active-low, load wins over increment, 1-cycle update) between two burst requesters.
- Each requester asks for a burst of N consecutive addresses from a start address. The arbiter grants round-robin, loads the counter, then steps it once per word accepted by the consumer.
- Sits between the CPU/DMA-style requesters and the shared address counter.

Parameters:
- WordSize, 16, width of the counter, start addresses and ctr_data.
- LenSize, 8, width of the burst length inputs; len 0 means 2^LenSize words.

Ports:
- clk       input   1           system clock, all state on posedge.
- reset     input   1           synchronous, active-high reset.
- req0      input   1           requester 0 burst request, level; held until done0.
- addr0     input   WordSize    requester 0 start address, stable while req0 is high.
- len0      input   LenSize     requester 0 word count, stable while req0 is high.
- req1      input   1           requester 1 burst request.
- addr1     input   WordSize    requester 1 start address.
- len1      input   LenSize     requester 1 word count.
- ready     input   1           consumer accepts the current word this cycle.
- gnt0      output  1           requester 0 owns the counter.
- gnt1      output  1           requester 1 owns the counter.
- done0     output  1           1-cycle pulse, requester 0 final word accepted.
- done1     output  1           1-cycle pulse, requester 1 final word accepted.
- valid     output  1           counter output holds a live burst address.
- last      output  1           current word is the final word of the burst.
- ctr_WE    output  1           counter write strobe, active low.
- ctr_IE    output  1           counter increment strobe, active low.
- ctr_data  output  WordSize    counter load value.

Behaviour:
- States:
  - IDLE: no owner.
  - LOAD: one cycle; ctr_WE=0, ctr_data=addr of the owner.
  - BURST: the counter holds the current address.
- Reset (sync, any state, including mid-burst):
  - State goes to IDLE, owner cleared, priority pointer set to "last served=1" so req0 wins the first tie.
  - Outputs after reset: gnt0=gnt1=0, done0=done1=0, valid=0, last=0, ctr_WE=1, ctr_IE=1, ctr_data=0.
  - The counter value is not cleared.
- IDLE, granting:
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high: grant the one not served last.
  - On grant, latch owner and remaining = len (len 0 loads 2^LenSize, so remaining is LenSize+1 bits), then go to LOAD.
- LOAD:
  - gntN=1, ctr_WE=0, ctr_data=addrN, ctr_IE=1, valid=0.
  - Next state is always BURST.
- BURST:
  - gntN=1, valid=1, last=(remaining==1).
  - ready=1 and last=0: ctr_IE=0 and remaining decrements.
  - ready=1 and last=1: ctr_IE=1, doneN=1 (combinational, this cycle), update priority pointer, next state IDLE.
  - ready=0: hold everything; ctr_IE=1, no decrement.
- Latency: request seen in IDLE at cycle t; LOAD at t+1; first address valid at t+2. Minimum burst turnaround is N+2 cycles when ready is held high.
- Back-to-back bursts:
  - The requester drops req on the edge after done.
  - One IDLE cycle always separates bursts.
  - With both requests pending, grants alternate.
- Outside LOAD, ctr_WE=1 and ctr_data=0. ctr_WE and ctr_IE are never both 0.
- Counter wrap past all-ones is allowed. The arbiter tracks words, not addresses.
- A req that drops mid-burst is ignored; the burst completes.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE, ST_LOAD, ST_BURST.
  - requester index constants.
- One sub-module is natural: rr_arb2, a 2-way round-robin pick with a pointer update input.
- The FSM, remaining counter and strobe decode stay in burst_ctr_arbiter.
- The bench instantiates the existing counter as the controlled datapath.

Test Plan:
- Single burst: req0, addr0=0x1000, len0=3, ready=1 -> gnt0 up at t+1, ctr_WE=0 with 0x1000 for one cycle. Counter reads 0x1000, 0x1001, 0x1002 with valid; last on 0x1002; done0 one pulse; back to IDLE.
- Tie and fairness: req0 and req1 held, len=2 each, addr 0x0010/0x0200 -> order after reset is 0, 1, 0, 1. One IDLE cycle between bursts; never gnt0 and gnt1 together.
- Backpressure: len1=4, ready low on 2nd and 3rd valid cycles -> counter holds 0x0201 for 3 cycles, no IE while ready=0. Total 4 accepted words; done1 only on accept of 0x0203.
- Boundaries:
  - addr0=0xFFFE, len0=3 -> 0xFFFE, 0xFFFF, 0x0000.
  - len0=0 -> exactly 256 accepted words, last only on the 256th.
- Reset mid-burst: reset during the 2nd word of a len=5 burst -> next cycle IDLE, gnt0=0, valid=0, ctr_WE=ctr_IE=1, no done pulse. A subsequent req1-only request is granted normally.

Source files
------------

// File: rtl/burst_ctr_arbiter_pkg.sv
// Shared definitions for the burst counter arbiter: FSM state encoding and
// requester indices used by the top and the round-robin picker.
package burst_ctr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    localparam logic REQ_0 = 1'b0;
    localparam logic REQ_1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. On a tie it picks the requester that was not
// served last; the pointer advances only when a burst completes.
module rr_arb2
    import burst_ctr_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic update,
    input  logic served,
    output logic pick,
    output logic any
);

    logic last_served;

    // Reset pointer says requester 1 was served last, so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_served <= REQ_1;
        end else if (update) begin
            last_served <= served;
        end
    end

    always_comb begin
        any  = req0 | req1;
        pick = REQ_0;
        if (req0 && req1) begin
            pick = ~last_served;
        end else if (req1) begin
            pick = REQ_1;
        end
    end

endmodule

// File: rtl/burst_ctr_arbiter.sv
// Shares one loadable up-counter between two burst requesters: grants
// round-robin, loads the start address, then steps once per accepted word.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; pick a requester and latch its word count
// ST_LOAD  | one cycle; counter write strobe with the owner's address
// ST_BURST | counter holds the current address; step on each accept
module burst_ctr_arbiter
    import burst_ctr_arbiter_pkg::*;
#(
    parameter int WordSize = 16,
    parameter int LenSize  = 8
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic [WordSize-1:0] addr0,
    input  logic [LenSize-1:0]  len0,
    input  logic                req1,
    input  logic [WordSize-1:0] addr1,
    input  logic [LenSize-1:0]  len1,
    input  logic                ready,
    output logic                gnt0,
    output logic                gnt1,
    output logic                done0,
    output logic                done1,
    output logic                valid,
    output logic                last,
    output logic                ctr_WE,
    output logic                ctr_IE,
    output logic [WordSize-1:0] ctr_data
);

    // A zero length means a full 2^LenSize-word burst, hence the extra bit.
    localparam logic [LenSize:0] FULL_LEN = {1'b1, {LenSize{1'b0}}};
    localparam logic [LenSize:0] ONE_LEFT = {{LenSize{1'b0}}, 1'b1};

    state_t             state;
    state_t             state_nxt;
    logic               owner;
    logic [LenSize:0]   remaining;
    logic               pick;
    logic               any_req;
    logic               take;
    logic               step;
    logic               finish;
    logic               is_last;
    logic [LenSize-1:0] len_pick;

    rr_arb2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .update (finish),
        .served (owner),
        .pick   (pick),
        .any    (any_req)
    );

    assign len_pick = (pick == REQ_1) ? len1 : len0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= REQ_0;
            remaining <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                owner     <= pick;
                remaining <= (len_pick == '0) ? FULL_LEN : {1'b0, len_pick};
            end else if (step) begin
                remaining <= remaining - ONE_LEFT;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        is_last   = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        valid     = 1'b0;
        ctr_WE    = 1'b1;
        ctr_IE    = 1'b1;
        ctr_data  = '0;

        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    take      = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                gnt0      = (owner == REQ_0);
                gnt1      = (owner == REQ_1);
                ctr_WE    = 1'b0;
                ctr_data  = (owner == REQ_1) ? addr1 : addr0;
                state_nxt = ST_BURST;
            end
            ST_BURST: begin
                gnt0    = (owner == REQ_0);
                gnt1    = (owner == REQ_1);
                valid   = 1'b1;
                is_last = (remaining == ONE_LEFT);
                if (ready) begin
                    if (is_last) begin
                        finish    = 1'b1;
                        done0     = (owner == REQ_0);
                        done1     = (owner == REQ_1);
                        state_nxt = ST_IDLE;
                    end else begin
                        step   = 1'b1;
                        ctr_IE = 1'b0;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        last = is_last;
    end

endmodule

// File: tb/tb_burst_ctr_arbiter.sv
// Scoreboard bench for burst_ctr_arbiter driving a behavioural loadable
// up-counter; expected word streams come from a burst-level arbitration model.
module tb_burst_ctr_arbiter;

    localparam int W = 16;
    localparam int L = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, req1, ready;
    logic [W-1:0] addr0, addr1;
    logic [L-1:0] len0, len1;
    logic         gnt0, gnt1, done0, done1, valid, last, ctr_WE, ctr_IE;
    logic [W-1:0] ctr_data;
    logic [W-1:0] ctr_q;

    always #5 clk = ~clk;

    burst_ctr_arbiter #(.WordSize(W), .LenSize(L)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .addr0    (addr0),
        .len0     (len0),
        .req1     (req1),
        .addr1    (addr1),
        .len1     (len1),
        .ready    (ready),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .valid    (valid),
        .last     (last),
        .ctr_WE   (ctr_WE),
        .ctr_IE   (ctr_IE),
        .ctr_data (ctr_data)
    );

    // Shared address counter: load wins over increment, never cleared by reset.
    always_ff @(posedge clk) begin
        if (!ctr_WE)      ctr_q <= ctr_data;
        else if (!ctr_IE) ctr_q <= ctr_q + 1'b1;
    end

    typedef struct {
        bit           owner;
        logic [W-1:0] addr;
        bit           last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done_seen0, done_seen1, prev_done;
    bit   model_last;
    int   ready_mode;
    int   vcount;
    int   hold_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_burst(input bit o, input logic [W-1:0] a, input logic [L-1:0] l);
        int   n;
        exp_t e;
        n = (l == 0) ? (1 << L) : int'(l);
        for (int i = 0; i < n; i++) begin
            e.owner = o;
            e.addr  = a + W'(i);
            e.last  = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_ready();
        case (ready_mode)
            1:       ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (valid) vcount++;
                ready = !(vcount == 2 || vcount == 3);
            end
            default: ready = 1'b1;
        endcase
    endtask

    // Monitor: pops one expected word per accepted word and checks strobes.
    always @(negedge clk) begin
        exp_t     e;
        logic [1:0] dexp;
        dexp = 2'b00;
        chk("one_grant", {31'd0, gnt0 & gnt1}, 0);
        chk("we_ie_exclusive", {31'd0, ~ctr_WE & ~ctr_IE}, 0);
        chk("ie_only_on_accept", {31'd0, ~ctr_IE & ~(valid & ready)}, 0);
        if (ctr_WE) chk("data_zero_outside_load", {16'd0, ctr_data}, 0);
        if (prev_done) chk("idle_gap", {30'd0, gnt1, gnt0}, 0);
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {16'd0, ctr_q}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("word_addr", {16'd0, ctr_q}, {16'd0, e.addr});
                chk("word_last", {31'd0, last}, {31'd0, e.last});
                chk("word_owner", {30'd0, gnt1, gnt0}, e.owner ? 2 : 1);
                if (e.last) dexp[e.owner] = 1'b1;
            end
        end
        chk("done_pulse", {30'd0, done1, done0}, {30'd0, dexp});
        if (done0) done_seen0 = 1'b1;
        if (done1) done_seen1 = 1'b1;
        prev_done = done0 | done1;
    end

    task automatic run_round(input bit r0, input bit r1,
                             input logic [W-1:0] a0, input logic [W-1:0] a1,
                             input logic [L-1:0] l0, input logic [L-1:0] l1);
        bit first;
        int c;
        first = (r0 && r1) ? ~model_last : r1;
        push_burst(first, first ? a1 : a0, first ? l1 : l0);
        if (r0 && r1) push_burst(~first, first ? a0 : a1, first ? l0 : l1);
        model_last = (r0 && r1) ? ~first : first;

        @(posedge clk); #1;
        addr0 = a0; len0 = l0; req0 = r0;
        addr1 = a1; len1 = l1; req1 = r1;
        vcount = 0; hold_cnt = 0;
        done_seen0 = 1'b0; done_seen1 = 1'b0;
        drive_ready();
        c = 0;
        while ((req0 || req1) && c < 2000) begin
            @(posedge clk); #1;
            c++;
            if (c == 1) begin
                chk("lat_gnt", {31'd0, first ? gnt1 : gnt0}, 1);
                chk("lat_we", {31'd0, ctr_WE}, 0);
                chk("lat_data", {16'd0, ctr_data}, {16'd0, first ? a1 : a0});
            end
            if (c == 2) begin
                chk("lat_valid", {31'd0, valid}, 1);
                chk("lat_first_addr", {16'd0, ctr_q}, {16'd0, first ? a1 : a0});
            end
            if (valid && ctr_q == 16'h0201) hold_cnt++;
            if (done_seen0) begin req0 = 1'b0; done_seen0 = 1'b0; end
            if (done_seen1) begin req1 = 1'b0; done_seen1 = 1'b0; end
            drive_ready();
        end
        chk("round_completes", {30'd0, req1, req0}, 0);
    endtask

    initial begin
        logic [1:0] pat;
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; ready = 1'b0;
        addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
        ready_mode = 0; model_last = 1'b1;
        done_seen0 = 1'b0; done_seen1 = 1'b0; prev_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", {30'd0, gnt1, gnt0}, 0);
        chk("rst_done", {30'd0, done1, done0}, 0);
        chk("rst_valid_last", {30'd0, valid, last}, 0);
        chk("rst_we_ie", {30'd0, ctr_WE, ctr_IE}, 3);
        chk("rst_data", {16'd0, ctr_data}, 0);
        reset = 1'b0;

        run_round(1, 0, 16'h1000, 16'h0000, 8'd3, 8'd0);
        run_round(1, 1, 16'h0010, 16'h0200, 8'd2, 8'd2);
        run_round(1, 1, 16'h0010, 16'h0200, 8'd2, 8'd2);

        ready_mode = 2;
        run_round(0, 1, 16'h0000, 16'h0200, 8'd0, 8'd4);
        chk("bp_hold_0201", hold_cnt, 3);
        ready_mode = 0;

        run_round(1, 0, 16'hFFFE, 16'h0000, 8'd3, 8'd0);
        run_round(1, 0, 16'h4000, 16'h0000, 8'd0, 8'd0);

        // Reset while the second word of a five-word burst is presented.
        @(posedge clk); #1;
        addr0 = 16'h0300; len0 = 8'd5; req0 = 1'b1; ready = 1'b1;
        push_burst(0, 16'h0300, 8'd5);
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_mid_word2", {16'd0, ctr_q}, 32'h0301);
        reset = 1'b1; ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; req0 = 1'b0;
        chk("rst_mid_gnt", {30'd0, gnt1, gnt0}, 0);
        chk("rst_mid_valid", {31'd0, valid}, 0);
        chk("rst_mid_we_ie", {30'd0, ctr_WE, ctr_IE}, 3);
        exp_q.delete();
        model_last = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_mid_no_done", {30'd0, done_seen1, done_seen0}, 0);
        run_round(0, 1, 16'h0000, 16'h0500, 8'd0, 8'd3);

        ready_mode = 1;
        for (int r = 0; r < 30; r++) begin
            pat = 2'($urandom_range(1, 3));
            run_round(pat[0], pat[1], W'($urandom), W'($urandom),
                      L'($urandom_range(1, 12)), L'($urandom_range(1, 12)));
        end

        repeat (2) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
